// File: rtl/sat_pkg.sv
// Shared types for the DPLL trail: entry encoding and the backtrack sequencer states.
package sat_pkg;

    localparam int VAR_W = 9;

    localparam logic TT_DECIDE = 1'b0;
    localparam logic TT_FORCED = 1'b1;

    typedef struct packed {
        logic             ent_type;
        logic             ent_val;
        logic [VAR_W-1:0] ent_var;
    } trail_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        CHECK,
        FLIP,
        UNSAT
    } tc_state_e;

endpackage

// File: rtl/trail_controller.sv
// Trail sequencer: arbitrates decision/implication pushes onto the trace table and runs the
// conflict backtrack loop (pop forced entries, flip the most recent decision).
module trail_controller #(
    parameter int VAR_W   = sat_pkg::VAR_W,
    parameter int DEPTH   = 512,
    parameter int LEVEL_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               decide_req,
    input  logic [VAR_W-1:0]   decide_var,
    input  logic               decide_val,
    output logic               decide_ack,
    input  logic               imply_req,
    input  logic [VAR_W-1:0]   imply_var,
    input  logic               imply_val,
    output logic               imply_ack,
    input  logic               conflict_req,
    output logic               tt_en,
    output logic               tt_rw,
    output logic               tt_type,
    output logic               tt_val,
    output logic [VAR_W-1:0]   tt_var,
    input  logic               tt_type_out,
    input  logic               tt_val_out,
    input  logic [VAR_W-1:0]   tt_var_out,
    input  logic               tt_empty,
    output logic               unassign_en,
    output logic [VAR_W-1:0]   unassign_var,
    output logic               flip_valid,
    output logic [VAR_W-1:0]   flip_var,
    output logic               flip_val,
    output logic               busy,
    output logic               full,
    output logic               unsat,
    output logic [LEVEL_W-1:0] decision_level
);
    import sat_pkg::*;

    tc_state_e          state;
    tc_state_e          state_nx;
    logic [LEVEL_W-1:0] occupancy;
    logic [LEVEL_W-1:0] level_q;
    logic [VAR_W-1:0]   flip_var_q;
    logic               flip_val_q;
    trail_entry_t       push_ent;
    logic               hit_decide;

    // Counters stick at their bounds instead of wrapping.
    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] x);
        return (x == LEVEL_W'(DEPTH)) ? x : x + 1'b1;
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] x);
        return (x == '0) ? x : x - 1'b1;
    endfunction

    assign full       = (occupancy == LEVEL_W'(DEPTH));
    assign hit_decide = (state == CHECK) && (tt_type_out == TT_DECIDE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (conflict_req) state_nx = POP;
            POP:     state_nx = tt_empty ? UNSAT : WAIT;
            WAIT:    state_nx = CHECK;
            CHECK:   state_nx = (tt_type_out == TT_FORCED) ? POP : FLIP;
            FLIP:    state_nx = IDLE;
            UNSAT:   state_nx = UNSAT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        decide_ack   = 1'b0;
        imply_ack    = 1'b0;
        tt_en        = 1'b0;
        tt_rw        = 1'b0;
        push_ent     = '0;
        unassign_en  = 1'b0;
        unassign_var = '0;
        flip_valid   = 1'b0;
        flip_var     = '0;
        flip_val     = 1'b0;
        case (state)
            IDLE: begin
                // A pending conflict blocks both pushes; a full trail stalls them.
                if (!conflict_req && !full) begin
                    if (imply_req) begin
                        imply_ack = 1'b1;
                        tt_en     = 1'b1;
                        tt_rw     = 1'b1;
                        push_ent  = '{ent_type: TT_FORCED, ent_val: imply_val, ent_var: imply_var};
                    end else if (decide_req) begin
                        decide_ack = 1'b1;
                        tt_en      = 1'b1;
                        tt_rw      = 1'b1;
                        push_ent   = '{ent_type: TT_DECIDE, ent_val: decide_val, ent_var: decide_var};
                    end
                end
            end
            POP: begin
                tt_en = !tt_empty;
            end
            CHECK: begin
                unassign_en  = 1'b1;
                unassign_var = tt_var_out;
            end
            FLIP: begin
                tt_en      = 1'b1;
                tt_rw      = 1'b1;
                push_ent   = '{ent_type: TT_FORCED, ent_val: ~flip_val_q, ent_var: flip_var_q};
                flip_valid = 1'b1;
                flip_var   = flip_var_q;
                flip_val   = ~flip_val_q;
            end
            default: ;
        endcase
    end

    assign tt_type        = push_ent.ent_type;
    assign tt_val         = push_ent.ent_val;
    assign tt_var         = push_ent.ent_var;
    assign busy           = (state != IDLE);
    assign unsat          = (state == UNSAT);
    assign decision_level = level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            occupancy <= '0;
            level_q   <= '0;
        end else begin
            if (tt_en && tt_rw) begin
                occupancy <= sat_inc(occupancy);
            end else if (tt_en && !tt_rw) begin
                occupancy <= sat_dec(occupancy);
            end
            if (decide_ack) begin
                level_q <= sat_inc(level_q);
            end else if (hit_decide) begin
                level_q <= sat_dec(level_q);
            end
        end
    end

    // The decision being undone is held for the FLIP push; only meaningful in FLIP.
    always_ff @(posedge clock) begin
        if (hit_decide) begin
            flip_var_q <= tt_var_out;
            flip_val_q <= tt_val_out;
        end
    end

endmodule

// File: tb/tb_trail_controller.sv
// Directed bench for trail_controller paired with a small behavioural trace table (DEPTH=8).
module tb_trail_controller;
    localparam int VAR_W   = 9;
    localparam int DEPTH   = 8;
    localparam int LEVEL_W = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               decide_req = 1'b0;
    logic [VAR_W-1:0]   decide_var = '0;
    logic               decide_val = 1'b0;
    logic               decide_ack;
    logic               imply_req = 1'b0;
    logic [VAR_W-1:0]   imply_var = '0;
    logic               imply_val = 1'b0;
    logic               imply_ack;
    logic               conflict_req = 1'b0;
    logic               tt_en, tt_rw, tt_type, tt_val;
    logic [VAR_W-1:0]   tt_var;
    logic               tt_type_out = 1'b0;
    logic               tt_val_out = 1'b0;
    logic [VAR_W-1:0]   tt_var_out = '0;
    logic               tt_empty;
    logic               unassign_en;
    logic [VAR_W-1:0]   unassign_var;
    logic               flip_valid;
    logic [VAR_W-1:0]   flip_var;
    logic               flip_val;
    logic               busy, full, unsat;
    logic [LEVEL_W-1:0] decision_level;

    int n_checks = 0;
    int n_pass   = 0;

    trail_controller #(.VAR_W(VAR_W), .DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clock(clock), .reset(reset),
        .decide_req(decide_req), .decide_var(decide_var), .decide_val(decide_val), .decide_ack(decide_ack),
        .imply_req(imply_req), .imply_var(imply_var), .imply_val(imply_val), .imply_ack(imply_ack),
        .conflict_req(conflict_req),
        .tt_en(tt_en), .tt_rw(tt_rw), .tt_type(tt_type), .tt_val(tt_val), .tt_var(tt_var),
        .tt_type_out(tt_type_out), .tt_val_out(tt_val_out), .tt_var_out(tt_var_out), .tt_empty(tt_empty),
        .unassign_en(unassign_en), .unassign_var(unassign_var),
        .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
        .busy(busy), .full(full), .unsat(unsat), .decision_level(decision_level)
    );

    always #5 clock = ~clock;

    // Trace table stand-in: stack with registered pop data (1-cycle read latency).
    logic [VAR_W+1:0] mem [0:DEPTH-1];
    int sp = 0;
    assign tt_empty = (sp == 0);

    always @(posedge clock) begin
        if (reset) begin
            sp          <= 0;
            tt_type_out <= 1'b0;
            tt_val_out  <= 1'b0;
            tt_var_out  <= '0;
        end else if (tt_en && tt_rw && sp < DEPTH) begin
            mem[sp] <= {tt_type, tt_val, tt_var};
            sp      <= sp + 1;
        end else if (tt_en && !tt_rw && sp > 0) begin
            {tt_type_out, tt_val_out, tt_var_out} <= mem[sp-1];
            sp <= sp - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               unas_n;
        logic [VAR_W-1:0] unas [4];
        int               flip_cyc;
        logic [VAR_W:0]   flip_bits;
        logic [12:0]      flip_push;
        logic             acks_seen;
        int               acks;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_flags", {unsat, full, decision_level}, 0);
        chk("rst_strobes", {tt_en, decide_ack, imply_ack, unassign_en, flip_valid}, 0);

        // Test 1: decide(5,1), imply(7,0), imply(9,1)
        @(negedge clock);
        reset = 1'b0;
        decide_req = 1'b1; decide_var = 9'd5; decide_val = 1'b1;
        #1;
        chk("t1_decide_ack", decide_ack, 1);
        chk("t1_decide_push", {tt_en, tt_rw, tt_type, tt_val, tt_var}, {1'b1, 1'b1, 1'b0, 1'b1, 9'd5});
        @(negedge clock);
        decide_req = 1'b0;
        imply_req = 1'b1; imply_var = 9'd7; imply_val = 1'b0;
        #1;
        chk("t1_imply7_ack", imply_ack, 1);
        chk("t1_imply7_push", {tt_en, tt_rw, tt_type, tt_val, tt_var}, {1'b1, 1'b1, 1'b1, 1'b0, 9'd7});
        @(negedge clock);
        imply_var = 9'd9; imply_val = 1'b1;
        #1;
        chk("t1_imply9_ack", imply_ack, 1);
        @(negedge clock);
        imply_req = 1'b0;
        #1;
        chk("t1_level", decision_level, 1);
        chk("t1_occupancy", sp, 3);

        // Test 2: conflict backtracks 9, 7, 5 then flips 5 at cycle 10
        @(negedge clock);
        conflict_req = 1'b1;
        #1;
        chk("t2_accept_no_strobe", {busy, tt_en}, 0);
        unas_n = 0; flip_cyc = -1; flip_bits = '0; flip_push = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            conflict_req = 1'b0;
            #1;
            if (unassign_en) begin
                if (unas_n < 4) unas[unas_n] = unassign_var;
                unas_n++;
            end
            if (flip_valid && flip_cyc < 0) begin
                flip_cyc  = c;
                flip_bits = {flip_val, flip_var};
                flip_push = {tt_en, tt_rw, tt_type, tt_val, tt_var};
            end
        end
        chk("t2_unassign_count", unas_n, 3);
        chk("t2_unassign_order", {unas[0], unas[1], unas[2]}, {9'd9, 9'd7, 9'd5});
        chk("t2_flip_cycle", flip_cyc, 10);
        chk("t2_flip_value", flip_bits, {1'b0, 9'd5});
        chk("t2_flip_push", flip_push, {1'b1, 1'b1, 1'b1, 1'b0, 9'd5});
        chk("t2_after", {busy, decision_level}, 0);
        chk("t2_trail", {sp[3:0], mem[0]}, {4'd1, 1'b1, 1'b0, 9'd5});

        // Test 3: arbitration priority
        @(negedge clock);
        decide_req = 1'b1; decide_var = 9'd3; decide_val = 1'b1;
        imply_req  = 1'b1; imply_var  = 9'd4; imply_val  = 1'b0;
        #1;
        chk("t3_imply_wins", {imply_ack, decide_ack, tt_var}, {1'b1, 1'b0, 9'd4});
        @(negedge clock);
        imply_req = 1'b0;
        #1;
        chk("t3_decide_next", {decide_ack, tt_type, tt_var}, {1'b1, 1'b0, 9'd3});
        @(negedge clock);
        decide_req   = 1'b0;
        conflict_req = 1'b1;
        imply_req    = 1'b1; imply_var = 9'd6; imply_val = 1'b1;
        #1;
        chk("t3_conflict_wins", {imply_ack, tt_en}, 0);
        acks_seen = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            conflict_req = 1'b0;
            #1;
            acks_seen = acks_seen | imply_ack | decide_ack;
            if (c == 3) chk("t3_unassign", {unassign_en, unassign_var}, {1'b1, 9'd3});
            if (c == 4) chk("t3_flip", {flip_valid, flip_val, flip_var}, {1'b1, 1'b0, 9'd3});
        end
        chk("t3_no_ack_busy", acks_seen, 0);
        @(negedge clock);
        #1;
        chk("t3_held_imply", {imply_ack, tt_var}, {1'b1, 9'd6});
        @(negedge clock);
        imply_req = 1'b0;
        #1;
        chk("t3_state", {sp[3:0], decision_level}, {4'd4, 4'd0});

        // Test 4: only forced entries -> unsat
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        imply_req = 1'b1; imply_var = 9'd2; imply_val = 1'b1;
        #1;
        chk("t4_imply_ack", imply_ack, 1);
        @(negedge clock);
        imply_req    = 1'b0;
        conflict_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            conflict_req = 1'b0;
            #1;
            if (c == 1) chk("t4_pop", {tt_en, tt_rw}, 2'b10);
            if (c == 3) chk("t4_unassign", {unassign_en, unassign_var}, {1'b1, 9'd2});
            if (c == 4) chk("t4_empty_pop", {tt_en, busy}, 2'b01);
            if (c == 5) chk("t4_unsat", {unsat, busy}, 2'b11);
        end
        @(negedge clock);
        decide_req = 1'b1; decide_var = 9'd1;
        imply_req  = 1'b1;
        #1;
        chk("t4_ignored", {decide_ack, imply_ack, tt_en}, 0);
        @(negedge clock);
        #1;
        chk("t4_sticky", {unsat, busy}, 2'b11);
        decide_req = 1'b0;
        imply_req  = 1'b0;

        // Test 5: fill to DEPTH, stall, conflict still accepted
        @(negedge clock);
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            reset = 1'b0;
            imply_req = 1'b1; imply_var = VAR_W'(10 + i); imply_val = 1'b0;
            #1;
            acks += int'(imply_ack);
        end
        chk("t5_fill_acks", acks, DEPTH);
        @(negedge clock);
        imply_var = 9'd20;
        #1;
        chk("t5_full_stall", {full, imply_ack, tt_en}, 3'b100);
        chk("t5_occupancy", sp, DEPTH);
        @(negedge clock);
        conflict_req = 1'b1;
        #1;
        chk("t5_conflict_accept", {imply_ack, busy, tt_en}, 0);
        @(negedge clock);
        conflict_req = 1'b0;
        #1;
        chk("t5_pop_full", {tt_en, tt_rw, full}, 3'b101);
        @(negedge clock);
        #1;
        chk("t5_after_pop", {full, busy, imply_ack}, 3'b010);

        // Test 6: reset during WAIT aborts the backtrack
        reset     = 1'b1;
        imply_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_outs_a", {decide_ack, imply_ack, tt_en, tt_rw, tt_type, tt_val, tt_var,
                          unassign_en, unassign_var}, 0);
        chk("t6_outs_b", {flip_valid, flip_var, flip_val, busy, full, unsat, decision_level}, 0);
        chk("t6_table_empty", tt_empty, 1);
        @(negedge clock);
        #1;
        chk("t6_stays_idle", {busy, tt_en, unassign_en}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
